// File: rtl/fetch_pc_pkg.sv
// Shared definitions for the instruction-fetch PC unit: state encoding,
// sequential PC step and default reset vector.
package fetch_pc_pkg;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC datapath: sequential PC+4 (wraps modulo 2^32) and the PC to load
// when execute redirects the front end.
module fetch_next_pc
  import fetch_pc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] seq_pc,
  output logic [31:0] next_pc_on_redirect
);

  assign seq_pc = pc + PC_STEP;

  // Redirect targets are taken verbatim; no alignment is enforced here.
  assign next_pc_on_redirect = redirect_valid ? redirect_pc : pc;

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, issues one memory request at a
// time and holds each fetched word for decode over a valid/ready handshake.
//
// state  | meaning
// S_INIT | one idle cycle after reset release
// S_REQ  | request presented at pc, waiting for memory to accept
// S_WAIT | one request outstanding, waiting for its response
// S_HOLD | fetched instruction offered to decode
module fetch_pc_unit
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        Inst_Req_Valid,
  input  logic        Inst_Req_Ready,
  output logic [31:0] Inst_Addr,
  input  logic        Inst_Valid,
  output logic        Inst_Ready,
  input  logic [31:0] Instruction,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic         drop, drop_n;
  logic [31:0]  if_inst_n, if_pc_n;
  logic [31:0]  seq_pc, redirect_target;

  fetch_next_pc u_next_pc (
    .pc                  (pc),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .seq_pc              (seq_pc),
    .next_pc_on_redirect (redirect_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_INIT;
      pc      <= RESET_PC;
      drop    <= 1'b0;
      if_inst <= 32'h0;
      if_pc   <= 32'h0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      drop    <= drop_n;
      if_inst <= if_inst_n;
      if_pc   <= if_pc_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    drop_n    = drop;
    if_inst_n = if_inst;
    if_pc_n   = if_pc;
    case (state)
      S_INIT: state_n = S_REQ;
      S_REQ: begin
        if (redirect_valid) pc_n = redirect_target;
        if (Inst_Req_Ready) begin
          state_n = S_WAIT;
          // An accepted request on the redirect cycle fetches the old path.
          if (redirect_valid) drop_n = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_n = redirect_target;
          if (Inst_Valid) begin
            state_n = S_REQ;
            drop_n  = 1'b0;
          end else begin
            drop_n  = 1'b1;
          end
        end else if (Inst_Valid) begin
          if (drop) begin
            state_n = S_REQ;
            drop_n  = 1'b0;
          end else begin
            state_n   = S_HOLD;
            if_inst_n = Instruction;
            if_pc_n   = pc;
            pc_n      = seq_pc;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_n    = redirect_target;
          state_n = S_REQ;
        end else if (if_ready) begin
          state_n = S_REQ;
        end
      end
      default: state_n = S_INIT;
    endcase
  end

  // Handshake outputs decode from state only, never from inputs.
  assign Inst_Req_Valid = (state == S_REQ);
  assign Inst_Ready     = (state == S_WAIT);
  assign if_valid       = (state == S_HOLD);
  assign Inst_Addr      = pc;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vector table, hand-written redirect and
// reset sequences, then randomized traffic against a transaction-level model.
module tb_fetch_pc_unit;
  import fetch_pc_pkg::*;

  logic        clk, rst_n;
  logic        Inst_Req_Valid, Inst_Req_Ready;
  logic [31:0] Inst_Addr;
  logic        Inst_Valid, Inst_Ready;
  logic [31:0] Instruction;
  logic        if_valid, if_ready;
  logic [31:0] if_inst, if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int vectors = 0;
  int miscompares = 0;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
    .Inst_Addr(Inst_Addr), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
    .Instruction(Instruction), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rr, iv, ir;
    logic [31:0] ins;
    logic        e_rv, e_irdy, e_ifv;
    logic [31:0] e_addr, e_inst, e_pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rr, logic iv, logic [31:0] ins, logic ir,
                              logic e_rv, logic [31:0] e_addr, logic e_irdy,
                              logic e_ifv, logic [31:0] e_inst, logic [31:0] e_pc);
    vec_t v;
    v.rr = rr; v.iv = iv; v.ins = ins; v.ir = ir;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_irdy = e_irdy;
    v.e_ifv = e_ifv; v.e_inst = e_inst; v.e_pc = e_pc;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {29'h0, Inst_Req_Valid, Inst_Addr, Inst_Ready, if_valid, if_inst, if_pc};
  endfunction

  function automatic logic [127:0] pack_exp(logic rv, logic [31:0] a, logic irdy,
                                            logic ifv, logic [31:0] inst, logic [31:0] p);
    return {29'h0, rv, a, irdy, ifv, inst, p};
  endfunction

  task automatic cyc(logic rr, logic iv, logic [31:0] ins, logic ir,
                     logic rdv, logic [31:0] rpc);
    Inst_Req_Ready = rr; Inst_Valid = iv; Instruction = ins; if_ready = ir;
    redirect_valid = rdv; redirect_pc = rpc;
    @(negedge clk);
  endtask

  localparam logic [31:0] I0 = 32'h0000_0013, I1 = 32'h0010_0113;
  localparam logic [31:0] I2 = 32'h0050_0093, I3 = 32'h0030_0193;
  localparam logic [31:0] I4 = 32'h0040_0213;

  logic        rr_r, ir_r, rdv_r, iv_r, pending;
  logic [31:0] rpc_r, ins_r, paddr, exp_pc;
  int          delay, deliveries;

  initial begin
    rst_n = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // rr  iv  ins  ir | req_valid addr inst_ready if_valid if_inst if_pc
    tbl.push_back(mk(1, 0, 0,  1, 0, 32'h00, 0, 0, 0,  0));
    tbl.push_back(mk(1, 0, 0,  1, 1, 32'h00, 0, 0, 0,  0));
    tbl.push_back(mk(1, 1, I0, 1, 0, 32'h00, 1, 0, 0,  0));
    tbl.push_back(mk(1, 0, 0,  1, 0, 32'h04, 0, 1, I0, 32'h0));
    tbl.push_back(mk(1, 0, 0,  1, 1, 32'h04, 0, 0, I0, 32'h0));
    tbl.push_back(mk(1, 1, I1, 1, 0, 32'h04, 1, 0, I0, 32'h0));
    tbl.push_back(mk(1, 0, 0,  1, 0, 32'h08, 0, 1, I1, 32'h4));
    tbl.push_back(mk(1, 0, 0,  1, 1, 32'h08, 0, 0, I1, 32'h4));
    tbl.push_back(mk(1, 1, I2, 1, 0, 32'h08, 1, 0, I1, 32'h4));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0C, 0, 1, I2, 32'h8));
    tbl.push_back(mk(1, 0, 0,  1, 0, 32'h0C, 0, 1, I2, 32'h8));
    tbl.push_back(mk(1, 0, 0,  1, 1, 32'h0C, 0, 0, I2, 32'h8));
    tbl.push_back(mk(1, 1, I3, 1, 0, 32'h0C, 1, 0, I2, 32'h8));
    tbl.push_back(mk(1, 0, 0,  1, 0, 32'h10, 0, 1, I3, 32'hC));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 0, 0, 1, 1, 32'h10, 0, 0, I3, 32'hC));
    tbl.push_back(mk(1, 0, 0,  1, 1, 32'h10, 0, 0, I3, 32'hC));
    tbl.push_back(mk(1, 1, I4, 1, 0, 32'h10, 1, 0, I3, 32'hC));
    tbl.push_back(mk(1, 0, 0,  1, 0, 32'h14, 0, 1, I4, 32'h10));

    rst_n = 1'b1;
    foreach (tbl[i]) begin
      chk($sformatf("vec%0d", i), outs(),
          pack_exp(tbl[i].e_rv, tbl[i].e_addr, tbl[i].e_irdy,
                   tbl[i].e_ifv, tbl[i].e_inst, tbl[i].e_pc));
      cyc(tbl[i].rr, tbl[i].iv, tbl[i].ins, tbl[i].ir, 0, 0);
    end

    // Redirect while the request is stalled, then while a response is pending.
    chk("req_pre_redirect", {Inst_Req_Valid, Inst_Addr}, {1'b1, 32'h14});
    cyc(0, 0, 0, 1, 1, 32'h20);
    chk("redirect_stalled_req", {Inst_Req_Valid, Inst_Addr}, {1'b1, 32'h20});
    cyc(1, 0, 0, 1, 0, 0);
    chk("wait_pc20", {Inst_Ready, Inst_Addr}, {1'b1, 32'h20});
    cyc(0, 0, 0, 1, 1, 32'h100);
    chk("wait_redirect", {Inst_Ready, Inst_Addr}, {1'b1, 32'h100});
    cyc(0, 1, 32'hDEAD_BEEF, 1, 0, 0);
    chk("drop_resp", {if_valid, Inst_Req_Valid, Inst_Addr}, {1'b0, 1'b1, 32'h100});
    cyc(1, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'h0AB0_0113, 1, 0, 0);
    chk("redirect_deliver", {if_valid, if_inst, if_pc}, {1'b1, 32'h0AB0_0113, 32'h100});
    cyc(0, 0, 0, 1, 0, 0);

    // Redirect on the same cycle the request is accepted.
    chk("seq_after_redirect", {Inst_Req_Valid, Inst_Addr}, {1'b1, 32'h104});
    cyc(1, 0, 0, 1, 1, 32'h200);
    chk("req_redirect_accept", {Inst_Ready, Inst_Addr}, {1'b1, 32'h200});
    cyc(0, 1, 32'hBAD0_0000, 1, 0, 0);
    chk("drop_after_accept", {if_valid, Inst_Req_Valid, Inst_Addr}, {1'b0, 1'b1, 32'h200});

    // PC wrap, then asynchronous reset in S_WAIT with a late response.
    cyc(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
    chk("wrap_target", {Inst_Req_Valid, Inst_Addr}, {1'b1, 32'hFFFF_FFFC});
    cyc(1, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'h0FF0_0013, 0, 0, 0);
    chk("wrap_hold", {if_valid, if_pc, Inst_Addr}, {1'b1, 32'hFFFF_FFFC, 32'h0});
    cyc(0, 0, 0, 1, 0, 0);
    chk("wrap_req", {Inst_Req_Valid, Inst_Addr}, {1'b1, 32'h0});
    cyc(1, 0, 0, 1, 0, 0);
    chk("wait_before_reset", {127'h0, Inst_Ready}, 128'h1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", outs(), pack_exp(0, 32'h0, 0, 0, 0, 0));
    Inst_Valid = 1'b1; Instruction = 32'h5555_AAAA;
    @(negedge clk);
    chk("reset_held", outs(), pack_exp(0, 32'h0, 0, 0, 0, 0));
    rst_n = 1'b1;
    cyc(0, 1, 32'h5555_AAAA, 1, 0, 0);
    chk("late_resp_ignored", outs(), pack_exp(1, 32'h0, 0, 0, 0, 0));
    cyc(0, 1, 32'h5555_AAAA, 1, 0, 0);
    chk("late_resp_stall", outs(), pack_exp(1, 32'h0, 0, 0, 0, 0));

    // Randomized traffic against a transaction-level model.
    rst_n = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    exp_pc = 32'h0; pending = 1'b0; delay = 0; deliveries = 0; paddr = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      rr_r  = ($urandom_range(0, 9) < 7);
      ir_r  = ($urandom_range(0, 9) < 6);
      rdv_r = (i >= 1) && ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 7))
        0:       rpc_r = 32'hFFFF_FFFC;
        1:       rpc_r = $urandom;
        default: rpc_r = $urandom & 32'h0000_0FFC;
      endcase
      iv_r = 1'b0; ins_r = 32'h0;
      if (pending) begin
        if (delay > 0) delay--;
        else begin
          iv_r = 1'b1; ins_r = mem_word(paddr);
          chk("resp_accepted", {127'h0, Inst_Ready}, 128'h1);
          pending = 1'b0;
        end
      end
      if (if_valid && ir_r) begin
        chk("deliver", {64'h0, if_pc, if_inst}, {64'h0, exp_pc, mem_word(exp_pc)});
        exp_pc += 32'd4;
        deliveries++;
      end
      if (Inst_Req_Valid && rr_r) begin
        if (!rdv_r) chk("req_addr", {96'h0, Inst_Addr}, {96'h0, exp_pc});
        chk("one_outstanding", {127'h0, pending}, 128'h0);
        pending = 1'b1; paddr = Inst_Addr; delay = $urandom_range(0, 2);
      end
      if (rdv_r) exp_pc = rpc_r;
      cyc(rr_r, iv_r, ins_r, ir_r, rdv_r, rpc_r);
    end
    chk("liveness", {127'h0, deliveries > 100}, 128'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
